farm_road_car_detector: RTL

// Upstream stage of the highway/farm-road traffic controller; produces its car-waiting input C.
// It synchronises and debounces the raw farm-road loop sensor, then counts arriving cars.

---
 rtl/farm_road_car_detector.sv | 128 ++++++++++++
 1 files changed

// File: rtl/farm_road_car_detector.sv
// Farm-road car detector: syncs and debounces the loop sensor, queues arrivals,
// drains them at a fixed headway under FG, and raises C while cars wait on red.
`default_nettype none

module farm_road_car_detector #(
  parameter int DEB_CYCLES    = 4,
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             FG,
  output logic             C,
  output logic [CNT_W-1:0] car_count,
  output logic             ovf
);

  localparam int DB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HW_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEB_CYCLES - 1);
  localparam logic [HW_W-1:0]  HW_LAST = HW_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    SERVING = 2'd2
  } state_t;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [HW_W-1:0]  hw_q, hw_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;
  logic             arrival;
  logic             depart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      db_q     <= '0;
      hw_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      db_q     <= db_d;
      hw_q     <= hw_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  // Debounce, headway and queue counter
  always_comb begin
    s1_d     = sensor_raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    db_d     = '0;
    arrival  = 1'b0;
    if (s2_q != stable_q) begin
      if (db_q == DB_LAST) begin
        stable_d = s2_q;
        arrival  = s2_q;
      end else begin
        db_d = db_q + 1'b1;
      end
    end

    depart = 1'b0;
    hw_d   = '0;
    if (FG && (count_q != '0)) begin
      if (hw_q == HW_LAST) begin
        depart = 1'b1;
      end else begin
        hw_d = hw_q + 1'b1;
      end
    end

    count_d = count_q;
    ovf_d   = ovf_q;
    if (arrival && !depart) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (depart && !arrival) begin
      count_d = count_q - 1'b1;
    end
  end

  // State follows the registered count, so C lags the count by one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (FG)                    state_d = SERVING;
        else if (count_q != '0)    state_d = WAITING;
      end
      WAITING: begin
        if (FG)                    state_d = SERVING;
        else if (count_q == '0)    state_d = IDLE;
      end
      SERVING: begin
        if (!FG)                   state_d = (count_q == '0) ? IDLE : WAITING;
      end
      default:                     state_d = IDLE;
    endcase
  end

  assign C         = (state_q == WAITING);
  assign car_count = count_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire
